// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, talks to a variable-latency imem,
// buffers returned words in a small prefetch queue and feeds the IF/ID register.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOOP     = 32'h0000_0000
) (
   input  logic                      clock,
   input  logic                      reset_n,
   output logic                      imem_req,
   output logic [31:0]               imem_addr,
   input  logic                      imem_ack,
   input  logic [31:0]               imem_rdata,
   input  logic                      stall,
   input  logic                      redirect,
   input  logic [31:0]               redirect_pc,
   output logic [31:0]               ifid_ir,
   output logic [31:0]               ifid_pc,
   output logic                      ifid_valid,
   output logic [$clog2(DEPTH):0]    q_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t          state, state_nx;
   logic [31:0]     fetch_pc, fetch_pc_nx;
   logic            imem_req_nx;
   logic [31:0]     imem_addr_nx;
   logic [31:0]     rpc;

   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [31:0]     q_ir [DEPTH];
   logic [31:0]     q_pc [DEPTH];

   logic            ack_ok, pop, bypass, push;
   logic            has_room, room_after_push;
   logic [CW-1:0]   fill_after_push;

   assign rpc = redirect_pc & 32'hFFFF_FFFC;

   // Queue/bypass decisions; redirect overrides everything this cycle
   always_comb begin
      ack_ok          = (state == WAIT) && imem_ack && !redirect;
      pop             = !redirect && !stall && (q_count != '0);
      bypass          = !redirect && !stall && (q_count == '0) && ack_ok;
      push            = ack_ok && !bypass;
      has_room        = q_count < DEPTH_C;
      fill_after_push = q_count + {{AW{1'b0}}, push};
      room_after_push = fill_after_push < DEPTH_C;
   end

   // Fetch FSM next state; no credit is taken for a same-cycle pop
   always_comb begin
      state_nx     = state;
      fetch_pc_nx  = fetch_pc;
      imem_req_nx  = imem_req;
      imem_addr_nx = imem_addr;
      unique case (state)
         IDLE: begin
            imem_req_nx = 1'b0;
            if (redirect) begin
               fetch_pc_nx = rpc;
            end else if (has_room) begin
               imem_req_nx  = 1'b1;
               imem_addr_nx = fetch_pc;
               state_nx     = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               fetch_pc_nx = rpc;
               if (imem_ack) imem_addr_nx = rpc;
               else          state_nx     = DROP;
            end else if (imem_ack) begin
               fetch_pc_nx = imem_addr + 32'd4;
               if (room_after_push) begin
                  imem_addr_nx = imem_addr + 32'd4;
               end else begin
                  imem_req_nx = 1'b0;
                  state_nx    = IDLE;
               end
            end
         end
         DROP: begin
            // The in-flight wrong-path word is swallowed when it returns
            if (redirect) fetch_pc_nx = rpc;
            if (imem_ack) begin
               imem_addr_nx = redirect ? rpc : fetch_pc;
               state_nx     = WAIT;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         state     <= state_nx;
         fetch_pc  <= fetch_pc_nx;
         imem_req  <= imem_req_nx;
         imem_addr <= imem_addr_nx;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q_count <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else if (redirect) begin
         q_count <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   q_count <= q_count + CW'(1);
            2'b01:   q_count <= q_count - CW'(1);
            default: q_count <= q_count;
         endcase
      end
   end

   // Queue storage carries no reset; occupancy alone says what is live
   always_ff @(posedge clock) begin
      if (push) begin
         q_ir[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr] <= imem_addr;
      end
   end

   // IF/ID register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ifid_ir    <= NOOP;
         ifid_pc    <= 32'h0000_0000;
         ifid_valid <= 1'b0;
      end else if (redirect) begin
         ifid_ir    <= NOOP;
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         if (pop) begin
            ifid_ir    <= q_ir[rd_ptr];
            ifid_pc    <= q_pc[rd_ptr];
            ifid_valid <= 1'b1;
         end else if (bypass) begin
            ifid_ir    <= imem_rdata;
            ifid_pc    <= imem_addr;
            ifid_valid <= 1'b1;
         end else begin
            ifid_ir    <= NOOP;
            ifid_valid <= 1'b0;
         end
      end
   end

endmodule
